// File: rtl/add_sub.sv
// add_sub: registered unsigned adder/subtractor with carry-chain input.
// One shared adder handles both directions: subtraction adds the inverted
// subtrahend with an inverted carry-in. Both carry flags are then inverted
// so that they read as borrows. Every output is a flop, so there is no
// combinational path from the inputs to the outputs.
module add_sub #(
    parameter int WIDTH = 16
) (
    input  logic             op,
    input  logic             oc,
    output logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             c_out,
    output logic             h_out,
    input  logic             clk,
    input  logic             rst
);

    localparam int HALF = WIDTH / 2;

    logic             ci;
    logic             carry_in;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   full_sum;
    logic [HALF:0]    half_sum;

    logic [WIDTH-1:0] y_d;
    logic [WIDTH-1:0] y_q;
    logic             c_d;
    logic             c_q;
    logic             h_d;
    logic             h_q;

    // Shared adder: a + (b ^ op) + (ci ^ op); flags flipped to borrows on subtract
    always_comb begin
        ci       = oc & c_in;
        b_eff    = b ^ {WIDTH{op}};
        carry_in = ci ^ op;
        full_sum = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, carry_in};
        half_sum = {1'b0, a[HALF-1:0]} + {1'b0, b_eff[HALF-1:0]}
                 + {{HALF{1'b0}}, carry_in};
        y_d      = full_sum[WIDTH-1:0];
        c_d      = full_sum[WIDTH] ^ op;
        h_d      = half_sum[HALF] ^ op;
    end

    // Result registers; reset clears them and takes priority over the update
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q <= '0;
            c_q <= 1'b0;
            h_q <= 1'b0;
        end else begin
            y_q <= y_d;
            c_q <= c_d;
            h_q <= h_d;
        end
    end

    assign y     = y_q;
    assign c_out = c_q;
    assign h_out = h_q;

endmodule

// File: tb/tb_add_sub.sv
// tb_add_sub: self-checking bench for add_sub (WIDTH = 16).
// Expected results come from plain integer arithmetic on the operands.
module tb_add_sub;

    logic        clk;
    logic        rst;
    logic        op;
    logic        oc;
    logic [15:0] y;
    logic [15:0] a;
    logic [15:0] b;
    logic        c_in;
    logic        c_out;
    logic        h_out;

    int checks;
    int errors;

    add_sub #(.WIDTH(16)) dut (
        .op    (op),
        .oc    (oc),
        .y     (y),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .c_out (c_out),
        .h_out (h_out),
        .clk   (clk),
        .rst   (rst)
    );

    // Free-running clock with a 10-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: returns {c_out, h_out, y} from integer arithmetic
    function automatic logic [17:0] model(input bit m_op, input bit m_oc,
                                          input bit m_cin,
                                          input logic [15:0] m_a,
                                          input logic [15:0] m_b);
        int ai, bi, ci, al, bl, res;
        logic [15:0] ry;
        logic rc, rh;
        ai = int'(m_a);
        bi = int'(m_b);
        ci = (m_oc && m_cin) ? 1 : 0;
        al = ai % 256;
        bl = bi % 256;
        if (!m_op) begin
            res = ai + bi + ci;
            ry  = res[15:0];
            rc  = (res >= 65536);
            rh  = ((al + bl + ci) >= 256);
        end else begin
            res = ai - bi - ci + 65536;
            ry  = res[15:0];
            rc  = (ai < bi + ci);
            rh  = (al < bl + ci);
        end
        return {rc, rh, ry};
    endfunction

    task automatic drive(input bit d_op, input bit d_oc, input bit d_cin,
                         input logic [15:0] d_a, input logic [15:0] d_b);
        op   = d_op;
        oc   = d_oc;
        c_in = d_cin;
        a    = d_a;
        b    = d_b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [17:0] exp;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 16'h1234, 16'h4321);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({c_out, h_out, y} !== 18'h0) begin
                errors++;
                $display("[TB] FAIL reset_hold%0d: got c=%b h=%b y=%h expected c=0 h=0 y=0000",
                         i, c_out, h_out, y);
            end
        end
        rst = 1'b0;
        tick();
        exp = {2'b00, 16'h5555};
        checks++;
        if ({c_out, h_out, y} !== exp) begin
            errors++;
            $display("[TB] FAIL reset_release: got %h expected %h", {c_out, h_out, y}, exp);
        end
    endtask

    task automatic test_directed();
        logic [17:0] exp [5];
        bit          v_op [5];
        bit          v_oc [5];
        bit          v_ci [5];
        logic [15:0] v_a  [5];
        logic [15:0] v_b  [5];
        v_op = '{0, 0, 0, 1, 1};
        v_oc = '{0, 0, 1, 0, 1};
        v_ci = '{1, 0, 1, 0, 1};
        v_a  = '{16'h0032, 16'hFFCE, 16'hFFFF, 16'h0032, 16'h0100};
        v_b  = '{16'h0064, 16'h0064, 16'h0000, 16'h0064, 16'h0000};
        exp  = '{{2'b00, 16'h0096}, {2'b11, 16'h0032}, {2'b11, 16'h0000},
                 {2'b11, 16'hFFCE}, {2'b01, 16'h00FF}};
        for (int i = 0; i < 5; i++) begin
            drive(v_op[i], v_oc[i], v_ci[i], v_a[i], v_b[i]);
            tick();
            checks++;
            if ({c_out, h_out, y} !== exp[i]) begin
                errors++;
                $display("[TB] FAIL directed%0d: got %h expected %h", i, {c_out, h_out, y}, exp[i]);
            end
        end
    endtask

    task automatic test_corners();
        logic [17:0] exp;
        // 0 - 0 - 1 wraps to all ones with both borrows
        drive(1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000);
        tick();
        exp = {2'b11, 16'hFFFF};
        checks++;
        if ({c_out, h_out, y} !== exp) begin
            errors++;
            $display("[TB] FAIL zero_minus_borrow: got %h expected %h", {c_out, h_out, y}, exp);
        end
        // all ones + all ones + 1
        drive(1'b0, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
        tick();
        exp = {2'b11, 16'hFFFF};
        checks++;
        if ({c_out, h_out, y} !== exp) begin
            errors++;
            $display("[TB] FAIL ones_plus_ones: got %h expected %h", {c_out, h_out, y}, exp);
        end
        // oc=0 must ignore c_in on subtract
        drive(1'b1, 1'b0, 1'b1, 16'h0100, 16'h0000);
        tick();
        exp = {2'b00, 16'h0100};
        checks++;
        if ({c_out, h_out, y} !== exp) begin
            errors++;
            $display("[TB] FAIL sub_cin_ignored: got %h expected %h", {c_out, h_out, y}, exp);
        end
    endtask

    task automatic test_no_comb_path();
        logic [17:0] held;
        drive(1'b0, 1'b0, 1'b0, 16'h00F0, 16'h0020);
        tick();
        held = {c_out, h_out, y};
        checks++;
        if (held !== {2'b01, 16'h0110}) begin
            errors++;
            $display("[TB] FAIL pre_hold: got %h expected %h", held, {2'b01, 16'h0110});
        end
        drive(1'b1, 1'b1, 1'b1, 16'h0000, 16'hFFFF);
        #3;
        checks++;
        if ({c_out, h_out, y} !== {2'b01, 16'h0110}) begin
            errors++;
            $display("[TB] FAIL output_hold: got %h expected %h", {c_out, h_out, y}, {2'b01, 16'h0110});
        end
    endtask

    task automatic test_reset_midstream();
        logic [17:0] exp;
        drive(1'b0, 1'b0, 1'b0, 16'h7000, 16'h7000);
        tick();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 16'h1111, 16'h2222);
        tick();
        checks++;
        if ({c_out, h_out, y} !== 18'h0) begin
            errors++;
            $display("[TB] FAIL reset_midstream: got %h expected %h", {c_out, h_out, y}, 18'h0);
        end
        rst = 1'b0;
        tick();
        exp = model(1'b0, 1'b0, 1'b0, 16'h1111, 16'h2222);
        checks++;
        if ({c_out, h_out, y} !== exp) begin
            errors++;
            $display("[TB] FAIL after_midstream_reset: got %h expected %h", {c_out, h_out, y}, exp);
        end
    endtask

    task automatic test_sweep();
        logic [17:0] exp;
        logic [15:0] va, vb;
        bit          vci;
        for (int mode = 0; mode < 4; mode++) begin
            for (int k = 0; k * 50 <= 65535; k++) begin
                va  = 16'(k * 50);
                vb  = 16'(65535 - k * 50);
                vci = k[0];
                if (k % 3 == 0) vb = va;
                drive(mode[1], mode[0], vci, va, vb);
                exp = model(mode[1], mode[0], vci, va, vb);
                tick();
                checks++;
                if ({c_out, h_out, y} !== exp) begin
                    errors++;
                    $display("[TB] FAIL sweep op=%0d oc=%0d a=%h b=%h ci=%0d: got %h expected %h",
                             mode[1], mode[0], va, vb, vci, {c_out, h_out, y}, exp);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [17:0] exp;
        logic [15:0] va, vb;
        bit          vop, voc, vci;
        for (int i = 0; i < 2000; i++) begin
            vop = 1'($urandom_range(0, 1));
            voc = 1'($urandom_range(0, 1));
            vci = 1'($urandom_range(0, 1));
            va  = 16'($urandom);
            vb  = 16'($urandom);
            if (i % 16 == 0) vb = va;
            drive(vop, voc, vci, va, vb);
            exp = model(vop, voc, vci, va, vb);
            tick();
            checks++;
            if ({c_out, h_out, y} !== exp) begin
                errors++;
                $display("[TB] FAIL random op=%0d oc=%0d a=%h b=%h ci=%0d: got %h expected %h",
                         vop, voc, va, vb, vci, {c_out, h_out, y}, exp);
            end
        end
    endtask

    // Scenario sequence followed by the summary
    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        test_reset();
        test_directed();
        test_corners();
        test_no_comb_path();
        test_reset_midstream();
        test_sweep();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
